// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg: shared types for the memory/writeback sequencer.
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WB    = 2'd2,
        ABORT = 2'd3
    } wbseq_state_t;

    typedef enum logic [1:0] {
        OP_ALU   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } wbseq_op_t;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;

    // A load wins when execute marks both read and write.
    function automatic wbseq_op_t decode_op(input logic mem_read, input logic mem_write);
        if (mem_read) begin
            return OP_LOAD;
        end else if (mem_write) begin
            return OP_STORE;
        end
        return OP_ALU;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wbseq_timeout_cnt.sv
// ============================================================================
// wbseq_timeout_cnt: clear/enable counter flagging the last allowed cycle.
// Rev 1.0
// ============================================================================
`default_nettype none

module wbseq_timeout_cnt #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] C_TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tc = (r_count == C_TC_VAL);

endmodule

`default_nettype wire

// File: rtl/wb_mem_sequencer.sv
// ============================================================================
// wb_mem_sequencer: memory/writeback stage sequencer with dmem req/ack handshake.
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_mem_sequencer
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic [4:0]  rd,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [1:0]  wb_sel,
    output logic [31:0] wb_alu,
    output logic [31:0] wb_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic        stall,
    output logic        bus_err
);

    wbseq_state_t r_state;
    wbseq_state_t w_next;
    wbseq_op_t    r_op;
    wbseq_op_t    w_op;

    logic [31:0] r_alu;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [4:0]  r_rd;
    logic        r_reg_write;
    logic [1:0]  r_wb_sel;
    logic        r_bus_err;

    logic w_accept;
    logic w_in_req;
    logic w_tc;

    assign instr_ready = (r_state == IDLE) || (r_state == WB);
    assign w_accept    = instr_valid & instr_ready;
    assign w_op        = decode_op(mem_read, mem_write);
    assign w_in_req    = (r_state == REQ);

    wbseq_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_accept),
        .en    (w_in_req),
        .tc    (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, WB: begin
                if (w_accept) begin
                    w_next = (w_op == OP_ALU) ? WB : REQ;
                end else begin
                    w_next = IDLE;
                end
            end
            // An ack arriving on the final allowed cycle still completes normally.
            REQ: begin
                if (dmem_ack) begin
                    w_next = (r_op == OP_LOAD) ? WB : IDLE;
                end else if (w_tc) begin
                    w_next = ABORT;
                end
            end
            ABORT: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op        <= OP_ALU;
            r_alu       <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_wb_sel    <= WB_SEL_ALU;
            r_bus_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op        <= w_op;
                r_alu       <= alu_result;
                r_wdata     <= store_data;
                r_rd        <= rd;
                r_reg_write <= reg_write;
                if (w_op == OP_ALU) begin
                    r_wb_sel <= WB_SEL_ALU;
                end
            end
            if (w_in_req && dmem_ack && (r_op == OP_LOAD)) begin
                r_rdata  <= dmem_rdata;
                r_wb_sel <= WB_SEL_MEM;
            end
            if (w_in_req && !dmem_ack && w_tc) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign dmem_req   = w_in_req;
    assign dmem_we    = w_in_req & (r_op == OP_STORE);
    assign dmem_addr  = r_alu;
    assign dmem_wdata = r_wdata;
    assign wb_sel     = r_wb_sel;
    assign wb_alu     = r_alu;
    assign wb_rdata   = r_rdata;
    assign rf_we      = (r_state == WB) & r_reg_write & (r_rd != 5'd0);
    assign rf_waddr   = r_rd;
    assign stall      = ~instr_ready;
    assign bus_err    = r_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_wb_mem_sequencer.sv
// ============================================================================
// tb_wb_mem_sequencer: directed and randomized checks of wb_mem_sequencer.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_mem_sequencer;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        reg_write = 1'b0;
    logic [4:0]  rd = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] store_data = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic [1:0]  wb_sel;
    logic [31:0] wb_alu;
    logic [31:0] wb_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        stall;
    logic        bus_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: sticky error flag and last writeback select.
    logic       exp_bus_err = 1'b0;
    logic [1:0] exp_wb_sel  = 2'b00;

    always #5 clk = ~clk;

    wb_mem_sequencer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .rd          (rd),
        .alu_result  (alu_result),
        .store_data  (store_data),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .wb_sel      (wb_sel),
        .wb_alu      (wb_alu),
        .wb_rdata    (wb_rdata),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .stall       (stall),
        .bus_err     (bus_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic rd_f, input logic wr_f, input logic rw,
                           input logic [4:0] r, input logic [31:0] a, input logic [31:0] d);
        instr_valid = 1'b1;
        mem_read    = rd_f;
        mem_write   = wr_f;
        reg_write   = rw;
        rd          = r;
        alu_result  = a;
        store_data  = d;
    endtask

    task automatic idle_inputs();
        instr_valid = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
    endtask

    // Single ALU op from IDLE: writeback in the cycle after acceptance.
    task automatic run_alu(input logic rw, input logic [4:0] r, input logic [31:0] a);
        present(1'b0, 1'b0, rw, r, a, $urandom);
        chk("alu_ready", instr_ready, 1);
        step();
        idle_inputs();
        exp_wb_sel = 2'b00;
        chk("alu_rf_we", rf_we, rw && (r != 5'd0));
        chk("alu_waddr", rf_waddr, r);
        chk("alu_wb_sel", wb_sel, exp_wb_sel);
        chk("alu_wb_alu", wb_alu, a);
        chk("alu_stall", stall, 0);
        step();
        chk("alu_bus_err", bus_err, exp_bus_err);
    endtask

    // Memory op from IDLE; ack on REQ cycle ack_at (1-based), 0 = never acked.
    task automatic run_mem(input logic rd_f, input logic wr_f, input logic rw,
                           input logic [4:0] r, input logic [31:0] a, input logic [31:0] d,
                           input int ack_at, input logic [31:0] rdata);
        logic is_load;
        logic acked;
        int   req_cycles;
        is_load    = rd_f;
        acked      = 1'b0;
        req_cycles = 0;
        present(rd_f, wr_f, rw, r, a, d);
        chk("mem_ready", instr_ready, 1);
        step();
        idle_inputs();
        for (int k = 1; k <= TIMEOUT && !acked; k++) begin
            req_cycles++;
            chk("mem_req", dmem_req, 1);
            chk("mem_we", dmem_we, !is_load);
            chk("mem_addr", dmem_addr, a);
            if (!is_load) chk("mem_wdata", dmem_wdata, d);
            chk("mem_stall", stall, 1);
            chk("mem_rf_we", rf_we, 0);
            if (k == ack_at) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
                acked      = 1'b1;
            end
            step();
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
        end
        if (!acked) begin
            exp_bus_err = 1'b1;
            chk("abort_req_cycles", req_cycles, TIMEOUT);
            chk("abort_req", dmem_req, 0);
            chk("abort_stall", stall, 1);
            chk("abort_rf_we", rf_we, 0);
            step();
            chk("abort_ready", instr_ready, 1);
            chk("abort_rf_we2", rf_we, 0);
            chk("abort_wb_sel", wb_sel, exp_wb_sel);
        end else if (is_load) begin
            exp_wb_sel = 2'b01;
            chk("ld_wb_sel", wb_sel, exp_wb_sel);
            chk("ld_wb_rdata", wb_rdata, rdata);
            chk("ld_rf_we", rf_we, rw && (r != 5'd0));
            chk("ld_waddr", rf_waddr, r);
            chk("ld_stall", stall, 0);
            chk("ld_req", dmem_req, 0);
            step();
            chk("ld_after_rf_we", rf_we, 0);
        end else begin
            chk("st_ready", instr_ready, 1);
            chk("st_req", dmem_req, 0);
            chk("st_rf_we", rf_we, 0);
            chk("st_wb_sel", wb_sel, exp_wb_sel);
        end
        chk("mem_bus_err", bus_err, exp_bus_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) step();
        rst_n = 1'b1;
        chk("rst_ready", instr_ready, 1);
        chk("rst_stall", stall, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_wb_sel", wb_sel, 0);
        chk("rst_bus_err", bus_err, 0);

        // Back-to-back ALU ops
        present(1'b0, 1'b0, 1'b1, 5'd3, 32'h10, 32'h0);
        chk("b2b_stall0", stall, 0);
        step();
        chk("b2b_rf_we1", rf_we, 1);
        chk("b2b_waddr1", rf_waddr, 3);
        chk("b2b_wb_alu1", wb_alu, 32'h10);
        chk("b2b_wb_sel1", wb_sel, 0);
        chk("b2b_stall1", stall, 0);
        present(1'b0, 1'b0, 1'b1, 5'd4, 32'h20, 32'h0);
        step();
        idle_inputs();
        chk("b2b_rf_we2", rf_we, 1);
        chk("b2b_waddr2", rf_waddr, 4);
        chk("b2b_wb_alu2", wb_alu, 32'h20);
        chk("b2b_wb_sel2", wb_sel, 0);
        chk("b2b_stall2", stall, 0);
        step();
        chk("b2b_idle_rf_we", rf_we, 0);

        // Directed memory ops
        run_mem(1'b1, 1'b0, 1'b1, 5'd7, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        run_mem(1'b0, 1'b1, 1'b1, 5'd9, 32'h200, 32'hCAFEF00D, 1, 32'h0);
        run_mem(1'b1, 1'b0, 1'b1, 5'd0, 32'h300, 32'h0, 2, 32'h12345678);
        run_mem(1'b1, 1'b1, 1'b1, 5'd5, 32'h400, 32'h55AA55AA, 1, 32'h0BADF00D);
        run_mem(1'b1, 1'b0, 1'b1, 5'd6, 32'h500, 32'h0, TIMEOUT, 32'hA5A5A5A5);
        chk("late_ack_no_err", bus_err, 0);
        run_mem(1'b1, 1'b0, 1'b1, 5'd8, 32'h600, 32'h0, 0, 32'h0);
        run_alu(1'b1, 5'd10, 32'hFEED0001);
        chk("err_sticky", bus_err, 1);

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            int          kind;
            logic [4:0]  r;
            logic        rw;
            logic [31:0] a;
            logic [31:0] d;
            kind = $urandom_range(0, 3);
            r    = 5'($urandom_range(0, 31));
            rw   = 1'($urandom_range(0, 1));
            a    = $urandom;
            d    = $urandom;
            case (kind)
                0: run_alu(rw, r, a);
                1: run_mem(1'b1, 1'b0, rw, r, a, d, $urandom_range(0, TIMEOUT), $urandom);
                2: run_mem(1'b0, 1'b1, rw, r, a, d, $urandom_range(0, TIMEOUT), $urandom);
                default: run_mem(1'b1, 1'b1, rw, r, a, d, $urandom_range(0, TIMEOUT), $urandom);
            endcase
        end

        // Reset on the second REQ cycle, then a stray ack
        present(1'b1, 1'b0, 1'b1, 5'd12, 32'h700, 32'h0);
        step();
        idle_inputs();
        step();
        chk("mid_req_active", dmem_req, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_bus_err = 1'b0;
        exp_wb_sel  = 2'b00;
        chk("mrst_req", dmem_req, 0);
        chk("mrst_we", dmem_we, 0);
        chk("mrst_addr", dmem_addr, 0);
        chk("mrst_wdata", dmem_wdata, 0);
        chk("mrst_wb_sel", wb_sel, exp_wb_sel);
        chk("mrst_wb_alu", wb_alu, 0);
        chk("mrst_wb_rdata", wb_rdata, 0);
        chk("mrst_rf_we", rf_we, 0);
        chk("mrst_waddr", rf_waddr, 0);
        chk("mrst_bus_err", bus_err, exp_bus_err);
        chk("mrst_ready", instr_ready, 1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h13579BDF;
        step();
        dmem_ack = 1'b0;
        chk("stray_rf_we", rf_we, 0);
        chk("stray_rdata", wb_rdata, 0);
        chk("stray_ready", instr_ready, 1);
        chk("stray_req", dmem_req, 0);
        chk("stray_wb_sel", wb_sel, exp_wb_sel);
        run_alu(1'b1, 5'd1, 32'h0000CAFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_mem_sequencer.md
Name: wb_mem_sequencer

Overview:
- Sequences the memory/writeback stage of the 32-bit CPU.
- Accepts one instruction at a time from execute (ALU result, store data, control bits) and runs the req/ack handshake with a multi-cycle data memory.
- Drives the 2-bit writeback-select of the Read_Data/ALUresult writeback mux, plus register-file write address and enable.
- Stalls upstream while a memory access is outstanding; flags accesses that never complete.

Parameters:
- TIMEOUT, 16, max cycles in REQ waiting for dmem_ack before abort (≥2).
- CNT_W, 5, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- instr_valid  in  1  execute presents an instruction; held until instr_ready.
- instr_ready  out  1  instruction accepted this cycle when valid&ready.
- mem_read  in  1  load.
- mem_write  in  1  store.
- reg_write  in  1  instruction writes rd.
- rd  in  5  destination register.
- alu_result  in  32  ALU output / memory address.
- store_data  in  32  store write data.
- dmem_req  out  1  memory request, held until ack.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  address.
- dmem_wdata  out  32  write data.
- dmem_ack  in  1  one-cycle completion pulse.
- dmem_rdata  in  32  read data, valid with dmem_ack.
- wb_sel  out  2  writeback-mux select: 2'b00 ALUresult, 2'b01 Read_Data; 10/11 never driven.
- wb_alu  out  32  registered ALU result to mux.
- wb_rdata  out  32  registered load data to mux.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- stall  out  1  equals ~instr_ready.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Clock and reset: single clk; reset synchronous active-low. On rst_n=0 at a clk edge:
  - state→IDLE.
  - All outputs 0: dmem_*, wb_*, rf_*, bus_err, counter.
  - instr_ready=1 in the cycle after reset.
  - Reset mid-REQ drops dmem_req next cycle and discards the access.
- States: IDLE, REQ, WB, ABORT. instr_ready=1 in IDLE and WB only.
- Acceptance (valid&ready) captures alu_result, store_data, rd, reg_write, and op:
  - mem_read=1 → load; mem_read has priority if both are set.
  - else mem_write=1 → store.
  - else → ALU op.
- Transitions on acceptance:
  - ALU op → WB next cycle.
  - Load/store → REQ next cycle, with counter cleared.
- Without acceptance, IDLE stays IDLE and WB → IDLE.
- REQ:
  - dmem_req=1; dmem_we=1 for store; dmem_addr/dmem_wdata stable from captured values.
  - Counter increments each REQ cycle.
  - dmem_ack=1: load → WB with wb_rdata←dmem_rdata; store → IDLE.
  - ack=0 and counter==TIMEOUT-1 → ABORT. Ack in the same cycle wins over timeout.
  - Ack outside REQ is ignored.
- WB (exactly one cycle):
  - rf_we = captured reg_write & (rd≠0); rf_waddr = rd.
  - wb_sel = 01 for load, 00 for ALU op.
  - rf_we=0 in every other state; wb_sel holds its last value outside WB.
- ABORT (one cycle): bus_err←1 (sticky until reset), no register write, → IDLE. instr_ready=0.
- Latency:
  - ALU op: writeback 1 cycle after acceptance; back-to-back acceptance in WB gives 1 instruction/cycle.
  - Load: writeback cycle = ack cycle + 1.
  - Store: IDLE after the ack cycle.

Decomposition:
- Shared package cpu_pkg:
  - state enum wbseq_state_t {IDLE, REQ, WB, ABORT}.
  - WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01.
  - op enum {OP_ALU, OP_LOAD, OP_STORE}.
- One sub-module, wbseq_timeout_cnt: clear/enable counter with a terminal-count output.
- The existing writeback mux stays external; this block only drives its select and inputs.

Test Plan:
- ALU ops back-to-back: rd=3 alu=0x10, then rd=4 alu=0x20 on consecutive cycles → rf_we=1 on two consecutive cycles with waddr 3/4, wb_sel=00, stall never asserted.
- Load: addr 0x100, memory acks after 3 REQ cycles with rdata 0xDEADBEEF, rd=7 → dmem_req high 3 cycles, then WB with wb_sel=01, wb_rdata=0xDEADBEEF, rf_we=1, waddr=7; stall high from acceptance+1 until WB.
- Store: addr 0x200 data 0xCAFEF00D, ack after 1 cycle → dmem_we=1, wdata correct, rf_we never asserted, IDLE the cycle after ack.
- Timeout: TIMEOUT=4, no ack → dmem_req exactly 4 cycles, ABORT, bus_err=1 persisting, no rf_we; a later ALU op still writes back. Variant: ack on 4th cycle → normal completion, bus_err=0.
- rd=0 load and load+store both set → rf_we=0 for rd=0; dual-flag instruction behaves as load (dmem_we=0).
- Reset mid-REQ (rst_n=0 on 2nd REQ cycle) → next cycle dmem_req=0, all outputs 0, instr_ready=1; a late ack is ignored.
